// File: rtl/stall_ctrl.sv
// Multi-source CPU stall controller: gates the CPU clock enable from per-source
// stall requests, enforces a minimum stall length, aborts stuck sources and keeps statistics.
module stall_ctrl #(
    parameter int NUM_SRC   = 2,
    parameter int MIN_STALL = 1,
    parameter int TIMEOUT   = 16,
    parameter int CNT_W     = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] stall_req,
    input  logic               err_clr,
    output logic               proc_clk_en,
    output logic               stall_active,
    output logic [NUM_SRC-1:0] timeout_err,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic [CNT_W-1:0]   stall_events
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] TMO_C    = CW'(TIMEOUT);
    localparam logic [CW-1:0] MIN_C    = CW'(MIN_STALL);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_TOUT  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CW-1:0]      cnt_r;
    logic [CW-1:0]      cnt_nxt_s;
    logic [NUM_SRC-1:0] mask_r;
    logic [NUM_SRC-1:0] err_r;
    logic [CNT_W-1:0]   cyc_r;
    logic [CNT_W-1:0]   ev_r;
    logic               stall_active_r;

    logic [NUM_SRC-1:0] active_s;
    logic               any_s;
    logic               clk_en_s;
    logic               ev_inc_s;
    logic [NUM_SRC-1:0] tout_set_s;

    // Saturating increment: statistics stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        logic [CNT_W-1:0] r;
        if (inc && !(&v)) begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    assign active_s = stall_req & ~mask_r;
    assign any_s    = |active_s;

    // Next-state, stall counter and combinational clock-enable decode.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        clk_en_s    = 1'b1;
        ev_inc_s    = 1'b0;
        tout_set_s  = {NUM_SRC{1'b0}};
        case (state_r)
            ST_IDLE: begin
                clk_en_s = ~any_s;
                if (any_s) begin
                    state_nxt_s = ST_STALL;
                    cnt_nxt_s   = CNT_ONE;
                    ev_inc_s    = 1'b1;
                end else begin
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            ST_STALL: begin
                // Hold while any unmasked source asks, or the minimum length is not yet met.
                clk_en_s = ~(any_s | (cnt_r < MIN_C));
                if (any_s && (cnt_r == TMO_C)) begin
                    tout_set_s  = active_s;
                    state_nxt_s = ST_TOUT;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (!any_s && (cnt_r >= MIN_C)) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_TOUT: begin
                clk_en_s    = 1'b1;
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
            default: begin
                clk_en_s    = 1'b1;
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, mask, sticky error flags and statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            cnt_r          <= CNT_ZERO;
            mask_r         <= {NUM_SRC{1'b0}};
            err_r          <= {NUM_SRC{1'b0}};
            cyc_r          <= {CNT_W{1'b0}};
            ev_r           <= {CNT_W{1'b0}};
            stall_active_r <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            cnt_r          <= cnt_nxt_s;
            // A masked source is released once it has been seen low.
            mask_r         <= (mask_r & stall_req) | tout_set_s;
            err_r          <= (err_r & ~{NUM_SRC{err_clr}}) | tout_set_s;
            cyc_r          <= sat_inc(cyc_r, ~clk_en_s);
            ev_r           <= sat_inc(ev_r, ev_inc_s);
            stall_active_r <= (state_nxt_s == ST_STALL);
        end
    end

    assign proc_clk_en  = clk_en_s;
    assign stall_active = stall_active_r;
    assign timeout_err  = err_r;
    assign stall_cycles = cyc_r;
    assign stall_events = ev_r;

endmodule

// File: tb/tb_stall_ctrl.sv
// Bench for stall_ctrl: two parameterisations share stimulus and are compared each
// cycle against a rule-level reference model, plus directed scenario checks.
module tb_stall_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [1:0] stall_req;
    logic       err_clr;

    logic       en_a, act_a;
    logic [1:0] err_a;
    logic [3:0] cyc_a, ev_a;
    logic       en_b, act_b;
    logic [1:0] err_b;
    logic [31:0] cyc_b, ev_b;

    logic last_en_a, last_en_b;

    int checks = 0;
    int failures = 0;

    stall_ctrl #(.NUM_SRC(2), .MIN_STALL(3), .TIMEOUT(8), .CNT_W(4)) dut_a (
        .clk(clk), .reset(reset), .stall_req(stall_req), .err_clr(err_clr),
        .proc_clk_en(en_a), .stall_active(act_a), .timeout_err(err_a),
        .stall_cycles(cyc_a), .stall_events(ev_a));

    stall_ctrl #(.NUM_SRC(2), .MIN_STALL(1), .TIMEOUT(16), .CNT_W(32)) dut_b (
        .clk(clk), .reset(reset), .stall_req(stall_req), .err_clr(err_clr),
        .proc_clk_en(en_b), .stall_active(act_b), .timeout_err(err_b),
        .stall_cycles(cyc_b), .stall_events(ev_b));

    typedef struct {
        bit       busy;   // CPU is inside a stall
        bit       tout;   // the one released cycle after a timeout abort
        int       len;    // cycles spent in the current stall so far
        bit [1:0] mask;
        bit [1:0] err;
        longint   cyc;    // unbounded totals, saturated only when compared
        longint   ev;
    } mstate_t;

    mstate_t ma, mb;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic bit m_en(input mstate_t s, input bit [1:0] req, input int mins);
        bit [1:0] act;
        act = req & ~s.mask;
        if (s.tout) return 1'b1;
        if (!s.busy) return (act == 2'b00);
        return !((act != 2'b00) || (s.len < mins));
    endfunction

    function automatic mstate_t m_next(input mstate_t s, input bit [1:0] req, input bit clr,
                                       input bit rst, input int mins, input int tmo);
        mstate_t n;
        bit [1:0] act;
        n = s;
        if (rst) begin
            n = '{default: 0};
            return n;
        end
        act = req & ~s.mask;
        if (!m_en(s, req, mins)) n.cyc = s.cyc + 1;
        n.mask = s.mask & req;
        n.err  = clr ? 2'b00 : s.err;
        if (s.tout) begin
            n.tout = 1'b0;
        end else if (!s.busy) begin
            if (act != 2'b00) begin
                n.busy = 1'b1;
                n.len  = 1;
                n.ev   = s.ev + 1;
            end
        end else if ((act != 2'b00) && (s.len == tmo)) begin
            n.mask = n.mask | act;
            n.err  = n.err | act;
            n.tout = 1'b1;
            n.busy = 1'b0;
        end else if ((act == 2'b00) && (s.len >= mins)) begin
            n.busy = 1'b0;
        end else begin
            n.len = s.len + 1;
        end
        return n;
    endfunction

    task automatic step(input logic [1:0] r, input logic c, input logic rs);
        mstate_t na, nb;
        stall_req = r;
        err_clr   = c;
        reset     = rs;
        @(negedge clk);
        last_en_a = en_a;
        last_en_b = en_b;
        chk("en_a",  en_a,  m_en(ma, r, 3));
        chk("act_a", act_a, ma.busy);
        chk("err_a", err_a, ma.err);
        chk("cyc_a", cyc_a, sat(ma.cyc, 4));
        chk("ev_a",  ev_a,  sat(ma.ev, 4));
        chk("en_b",  en_b,  m_en(mb, r, 1));
        chk("act_b", act_b, mb.busy);
        chk("err_b", err_b, mb.err);
        chk("cyc_b", cyc_b, sat(mb.cyc, 32));
        chk("ev_b",  ev_b,  sat(mb.ev, 32));
        na = m_next(ma, r, c, rs, 3, 8);
        nb = m_next(mb, r, c, rs, 1, 16);
        @(posedge clk);
        ma = na;
        mb = nb;
        #1;
    endtask

    task automatic do_reset();
        step(2'b00, 1'b0, 1'b1);
        step(2'b00, 1'b0, 1'b0);
    endtask

    int       rem [2];
    logic [1:0] lvl;

    initial begin
        reset     = 1'b1;
        stall_req = 2'b00;
        err_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        ma = '{default: 0};
        mb = '{default: 0};
        do_reset();
        chk("rst_cyc_a", cyc_a, 4'd0);
        chk("rst_en_a", last_en_a, 1'b1);

        // Single-cycle request stretched to the minimum length
        step(2'b01, 1'b0, 1'b0);
        repeat (5) step(2'b00, 1'b0, 1'b0);
        chk("t1_ev_a", ev_a, 4'd1);
        chk("t1_cyc_a", cyc_a, 4'd3);
        chk("t1_cyc_b", cyc_b, 32'd1);

        // Five-cycle request held exactly its own length
        do_reset();
        repeat (5) step(2'b01, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        chk("t2_release_b", last_en_b, 1'b1);
        repeat (2) step(2'b00, 1'b0, 1'b0);
        chk("t2_cyc_b", cyc_b, 32'd5);

        // Chained sources form one stall
        do_reset();
        step(2'b01, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0);
        step(2'b11, 1'b0, 1'b0);
        repeat (4) step(2'b10, 1'b0, 1'b0);
        repeat (4) step(2'b00, 1'b0, 1'b0);
        chk("t3_ev_b", ev_b, 32'd1);
        chk("t3_cyc_b", cyc_b, 32'd7);
        chk("t3_cyc_a", cyc_a, 4'd7);

        // Stuck source aborted, re-raise stalls again, err_clr clears
        do_reset();
        repeat (20) step(2'b10, 1'b0, 1'b0);
        chk("t4_err_a", err_a, 2'b10);
        chk("t4_err_b", err_b, 2'b10);
        chk("t4_cyc_a", cyc_a, 4'd9);
        chk("t4_cyc_b", cyc_b, 32'd17);
        step(2'b00, 1'b0, 1'b0);
        step(2'b10, 1'b0, 1'b0);
        chk("t4_restall_a", last_en_a, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        repeat (4) step(2'b00, 1'b0, 1'b0);
        step(2'b00, 1'b1, 1'b0);
        chk("t4_clr_a", err_a, 2'b00);

        // Reset in the middle of a stall
        do_reset();
        step(2'b01, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b1);
        chk("t5_cyc_a", cyc_a, 4'd0);
        chk("t5_ev_b", ev_b, 32'd0);
        step(2'b00, 1'b0, 1'b0);
        chk("t5_en_a", last_en_a, 1'b1);

        // Counter saturation
        do_reset();
        for (int k = 0; k < 20; k++) begin
            step(2'b01, 1'b0, 1'b0);
            repeat (3) step(2'b00, 1'b0, 1'b0);
        end
        chk("t6_ev_a", ev_a, 4'd15);
        chk("t6_cyc_a", cyc_a, 4'd15);
        chk("t6_ev_b", ev_b, 32'd20);

        // Randomised bursts with occasional err_clr and reset
        do_reset();
        rem[0] = 0;
        rem[1] = 0;
        lvl = 2'b00;
        for (int i = 0; i < 1500; i++) begin
            for (int s = 0; s < 2; s++) begin
                if (rem[s] == 0) begin
                    lvl[s] = $urandom_range(0, 1) == 1;
                    rem[s] = lvl[s] ? $urandom_range(1, 22) : $urandom_range(1, 8);
                end
                rem[s] = rem[s] - 1;
            end
            step(lvl, $urandom_range(0, 15) == 0, $urandom_range(0, 299) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
